// File: rtl/mult_share_arbiter_if.sv
// Bundle between the requesters, the shared multiplier and the response consumer.
// slave is the arbiter side; master is the environment that drives requests and consumes responses.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic [3:0]           mul_a;
  logic [3:0]           mul_b;
  logic [7:0]           mul_product;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_product;
  logic                 rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, mul_product, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_product
  );

  modport master (
    output req_valid, req_a, req_b, mul_product, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_product
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one external 4x4 signed multiplier among NUM_REQ requesters
// and returns each product on a valid/ready response channel tagged with the requester ID.
module mult_share_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input logic                 clk,
  input logic                 rst,
  mult_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ID_W-1:0]    rr_ptr_reg;
  logic [ID_W-1:0]    cur_id_reg;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    grant_plus_one;
  logic               grant_valid;
  logic [NUM_REQ-1:0] ready_vec;

  logic [3:0]      mul_a_reg;
  logic [3:0]      mul_b_reg;
  logic            rsp_valid_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic [7:0]      rsp_product_reg;

  logic [3:0] a_slice [NUM_REQ];
  logic [3:0] b_slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign a_slice[gi] = bus.req_a[4*gi +: 4];
      assign b_slice[gi] = bus.req_b[4*gi +: 4];
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping; idx never reaches an unused ID code.
  always_comb begin
    int idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_valid && bus.req_valid[ID_W'(idx)]) begin
        grant_valid = 1'b1;
        grant       = ID_W'(idx);
      end
    end
  end

  assign grant_plus_one = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

  always_comb begin
    ready_vec = '0;
    if (state_reg == IDLE && grant_valid && !rst) ready_vec[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg      <= '0;
      cur_id_reg      <= '0;
      mul_a_reg       <= '0;
      mul_b_reg       <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= '0;
      rsp_product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            mul_a_reg  <= a_slice[grant];
            mul_b_reg  <= b_slice[grant];
            cur_id_reg <= grant;
            rr_ptr_reg <= grant_plus_one;
          end
        end
        // Operands have been stable on the multiplier for a full cycle here.
        ISSUE: begin
          rsp_product_reg <= bus.mul_product;
          rsp_id_reg      <= cur_id_reg;
          rsp_valid_reg   <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) rsp_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = ready_vec;
  assign bus.mul_a       = mul_a_reg;
  assign bus.mul_b       = mul_b_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_id      = rsp_id_reg;
  assign bus.rsp_product = rsp_product_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: a behavioural round-robin model and integer products predict every response.
module tb_mult_share_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_share_arbiter_if #(.NUM_REQ(N)) bus ();

  mult_share_arbiter #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The shared multiplier lives outside the arbiter.
  logic signed [7:0] ext_a, ext_b;
  assign ext_a = {{4{bus.mul_a[3]}}, bus.mul_a};
  assign ext_b = {{4{bus.mul_b[3]}}, bus.mul_b};
  assign bus.mul_product = ext_a * ext_b;

  int passes = 0;
  int total  = 0;
  int model_ptr = 0;
  int cycle = 0;
  logic [3:0] opa [N];
  logic [3:0] opb [N];

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int model_prod(input logic [3:0] a, input logic [3:0] b);
    return int'($signed(a)) * int'($signed(b));
  endfunction

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
    opa[i] = a;
    opb[i] = b;
    bus.req_a[4*i +: 4] = a;
    bus.req_b[4*i +: 4] = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  // Runs one arbitration from a negedge; returns at the negedge where rsp_valid is first seen.
  task automatic txn(input bit drop, output int gid, output logic [N-1:0] rdy, output int waits,
                     output int lat, output int rid, output int rprod, output int acc_cyc);
    waits = 0;
    while (waits < 20) begin
      #1;
      if (bus.req_ready != '0) break;
      @(negedge clk);
      waits++;
    end
    rdy = bus.req_ready;
    gid = -1;
    for (int i = 0; i < N; i++) if (rdy[i]) gid = i;
    acc_cyc = cycle;
    @(negedge clk);
    if (drop && gid >= 0) bus.req_valid[gid] = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rid   = int'(bus.rsp_id);
    rprod = int'($signed(bus.rsp_product));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); else passes++;
    total++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); else passes++;
    total++; if (bus.rsp_product !== 8'h00) $display("FAIL reset_rsp_product: got %h expected 00", bus.rsp_product); else passes++;
    total++; if (bus.mul_a !== 4'h0 || bus.mul_b !== 4'h0) $display("FAIL reset_mul: got %h/%h expected 0/0", bus.mul_a, bus.mul_b); else passes++;
    total++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); else passes++;
    rst = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    #1;
    total++; if (bus.req_ready !== 4'b0000) $display("FAIL idle_no_req_ready: got %b expected 0000", bus.req_ready); else passes++;
  endtask

  task automatic test_basic();
    int gid, waits, lat, rid, rprod, acc, exp_g, exp_p;
    logic [N-1:0] rdy;
    logic [7:0] held;
    @(negedge clk);
    set_req(0, 4'd3, 4'b1110);
    exp_g = model_grant(bus.req_valid);
    exp_p = model_prod(4'd3, 4'b1110);
    txn(1'b1, gid, rdy, waits, lat, rid, rprod, acc);
    model_ptr = (exp_g + 1) % N;
    total++; if (rdy !== 4'b0001) $display("FAIL basic_req_ready: got %b expected 0001", rdy); else passes++;
    total++; if (lat !== 2) $display("FAIL basic_latency: got %0d expected 2", lat); else passes++;
    total++; if (rid !== exp_g) $display("FAIL basic_rsp_id: got %0d expected %0d", rid, exp_g); else passes++;
    total++; if (rprod !== exp_p) $display("FAIL basic_rsp_product: got %0d expected %0d", rprod, exp_p); else passes++;
    held = bus.rsp_product;
    repeat (3) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_product !== 8'hFA || bus.rsp_id !== 2'd0 || bus.req_ready !== 4'b0000)
        $display("FAIL basic_hold: got v=%b id=%0d p=%h rdy=%b expected v=1 id=0 p=fa rdy=0000",
                 bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.req_ready);
      else passes++;
    end
    ack();
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL basic_release: got %b expected 0 (held %h)", bus.rsp_valid, held); else passes++;
  endtask

  task automatic test_rotation();
    int gid, waits, lat, rid, rprod, acc, prev_acc, exp_g, exp_p;
    logic [N-1:0] rdy;
    for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 4'b1000);
    bus.rsp_ready = 1'b1;
    prev_acc = 0;
    for (int t = 0; t < 5; t++) begin
      exp_g = model_grant(bus.req_valid);
      exp_p = model_prod(opa[exp_g], opb[exp_g]);
      txn(1'b0, gid, rdy, waits, lat, rid, rprod, acc);
      model_ptr = (exp_g + 1) % N;
      total++; if (rid !== exp_g || gid !== exp_g) $display("FAIL rotation_id[%0d]: got grant %0d id %0d expected %0d", t, gid, rid, exp_g); else passes++;
      total++; if (rprod !== exp_p) $display("FAIL rotation_product[%0d]: got %0d expected %0d", t, rprod, exp_p); else passes++;
      if (t > 0) begin
        total++; if (acc - prev_acc !== 3) $display("FAIL rotation_interval[%0d]: got %0d expected 3", t, acc - prev_acc); else passes++;
      end
      prev_acc = acc;
    end
    bus.req_valid = '0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_corners();
    int gid, waits, lat, rid, rprod, acc, r, exp_p;
    logic [N-1:0] rdy;
    logic [3:0] ca [3];
    logic [3:0] cb [3];
    logic [7:0] cexp [3];
    ca[0] = 4'b1000; cb[0] = 4'b1000; cexp[0] = 8'h40;
    ca[1] = 4'b1000; cb[1] = 4'b0111; cexp[1] = 8'hC8;
    ca[2] = 4'b0111; cb[2] = 4'b0111; cexp[2] = 8'h31;
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      r = $urandom_range(N - 1, 0);
      bus.req_a = 16'($urandom);
      bus.req_b = 16'($urandom);
      bus.req_valid = '0;
      set_req(r, ca[t], cb[t]);
      exp_p = model_prod(ca[t], cb[t]);
      txn(1'b1, gid, rdy, waits, lat, rid, rprod, acc);
      model_ptr = (r + 1) % N;
      total++; if (rid !== r) $display("FAIL corner_id[%0d]: got %0d expected %0d", t, rid, r); else passes++;
      total++; if (bus.rsp_product !== cexp[t] || rprod !== exp_p) $display("FAIL corner_product[%0d]: got %h expected %h", t, bus.rsp_product, cexp[t]); else passes++;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int gid, waits, lat, rid, rprod, acc, exp_g, exp_p;
    logic [N-1:0] rdy;
    logic [7:0] p0;
    bus.rsp_ready = 1'b0;
    set_req(0, 4'd5, 4'd6);
    txn(1'b1, gid, rdy, waits, lat, rid, rprod, acc);
    model_ptr = 1;
    p0 = bus.rsp_product;
    set_req(2, 4'b1101, 4'd4);
    repeat (5) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_product !== p0 || bus.req_ready !== 4'b0000 || p0 !== 8'd30)
        $display("FAIL backpressure_hold: got v=%b id=%0d p=%h rdy=%b expected v=1 id=0 p=1e rdy=0000",
                 bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.req_ready);
      else passes++;
    end
    bus.rsp_ready = 1'b1;
    exp_g = model_grant(bus.req_valid);
    exp_p = model_prod(opa[exp_g], opb[exp_g]);
    txn(1'b1, gid, rdy, waits, lat, rid, rprod, acc);
    model_ptr = (exp_g + 1) % N;
    total++; if (gid !== exp_g || waits !== 1) $display("FAIL backpressure_grant: got grant %0d after %0d waits expected %0d after 1", gid, waits, exp_g); else passes++;
    total++; if (rid !== exp_g || rprod !== exp_p) $display("FAIL backpressure_rsp: got id %0d prod %0d expected id %0d prod %0d", rid, rprod, exp_g, exp_p); else passes++;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_fairness();
    int gid, waits, lat, rid, rprod, acc, exp_g, exp_p;
    logic [N-1:0] rdy;
    int order [3];
    order[0] = 3; order[1] = 0; order[2] = 1;
    set_req(1, 4'd2, 4'd2);
    txn(1'b1, gid, rdy, waits, lat, rid, rprod, acc);
    model_ptr = 2;
    ack();
    set_req(0, 4'd1, 4'b1111);
    set_req(1, 4'b1010, 4'd3);
    set_req(3, 4'd7, 4'b1001);
    for (int t = 0; t < 3; t++) begin
      exp_g = model_grant(bus.req_valid);
      exp_p = model_prod(opa[exp_g], opb[exp_g]);
      txn(1'b1, gid, rdy, waits, lat, rid, rprod, acc);
      model_ptr = (exp_g + 1) % N;
      total++; if (rid !== exp_g || rid !== order[t]) $display("FAIL fairness_id[%0d]: got %0d expected %0d", t, rid, order[t]); else passes++;
      total++; if (rprod !== exp_p) $display("FAIL fairness_product[%0d]: got %0d expected %0d", t, rprod, exp_p); else passes++;
      ack();
    end
  endtask

  task automatic test_random();
    int gid, waits, lat, rid, rprod, acc, exp_g, exp_p;
    logic [N-1:0] rdy;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i] && $urandom_range(1, 0) == 1) set_req(i, 4'($urandom), 4'($urandom));
      if (bus.req_valid == '0) set_req($urandom_range(N - 1, 0), 4'($urandom), 4'($urandom));
      exp_g = model_grant(bus.req_valid);
      exp_p = model_prod(opa[exp_g], opb[exp_g]);
      txn(1'b1, gid, rdy, waits, lat, rid, rprod, acc);
      model_ptr = (exp_g + 1) % N;
      total++; if (gid !== exp_g || rid !== exp_g) $display("FAIL random_id[%0d]: got grant %0d id %0d expected %0d", t, gid, rid, exp_g); else passes++;
      total++; if (rprod !== exp_p || lat !== 2) $display("FAIL random_rsp[%0d]: got prod %0d lat %0d expected prod %0d lat 2", t, rprod, lat, exp_p); else passes++;
      repeat ($urandom_range(2, 0)) @(negedge clk);
      ack();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_issue();
    int gid, waits, lat, rid, rprod, acc, exp_g, exp_p;
    logic [N-1:0] rdy;
    set_req(1, 4'd5, 4'd3);
    #1;
    total++; if (bus.req_ready !== 4'b0010) $display("FAIL rstissue_grant: got %b expected 0010", bus.req_ready); else passes++;
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000 || bus.mul_a !== 4'h0 || bus.mul_b !== 4'h0)
      $display("FAIL rstissue_state: got v=%b rdy=%b a=%h b=%h expected v=0 rdy=0000 a=0 b=0",
               bus.rsp_valid, bus.req_ready, bus.mul_a, bus.mul_b);
    else passes++;
    rst = 1'b0;
    model_ptr = 0;
    repeat (2) @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL rstissue_no_rsp: got %b expected 0", bus.rsp_valid); else passes++;
    // Requesters 0 and 2: the winner reveals whether the pointer went back to 0.
    set_req(0, 4'b1100, 4'd3);
    set_req(2, 4'd6, 4'd2);
    exp_g = model_grant(bus.req_valid);
    exp_p = model_prod(opa[exp_g], opb[exp_g]);
    txn(1'b1, gid, rdy, waits, lat, rid, rprod, acc);
    model_ptr = (exp_g + 1) % N;
    total++; if (rid !== exp_g || rprod !== exp_p) $display("FAIL rstissue_ptr: got id %0d prod %0d expected id %0d prod %0d", rid, rprod, exp_g, exp_p); else passes++;
    ack();
    bus.req_valid = '0;
    set_req(3, 4'b1001, 4'd5);
    exp_g = model_grant(bus.req_valid);
    exp_p = model_prod(opa[exp_g], opb[exp_g]);
    txn(1'b1, gid, rdy, waits, lat, rid, rprod, acc);
    model_ptr = (exp_g + 1) % N;
    total++; if (rid !== 3 || rprod !== exp_p) $display("FAIL rstissue_id3: got id %0d prod %0d expected id 3 prod %0d", rid, rprod, exp_p); else passes++;
    ack();
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_rotation();
    test_corners();
    test_backpressure();
    test_fairness();
    test_random();
    test_reset_issue();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
